// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the serial BCD <-> Excess-3 converter.
// Mode encoding, per-mode addend and the digit-validity rule live here.
package bcd_xs3_pkg;

    localparam int DIGIT_W   = 4;
    localparam int BIT_CNT_W = $clog2(DIGIT_W);

    typedef enum logic {
        MODE_BCD2XS3 = 1'b0,
        MODE_XS32BCD = 1'b1
    } mode_e;

    localparam logic [DIGIT_W-1:0] K_BCD2XS3 = 4'b0011;
    localparam logic [DIGIT_W-1:0] K_XS32BCD = 4'b1101;

    function automatic logic [DIGIT_W-1:0] k_of(input mode_e m);
        return (m == MODE_XS32BCD) ? K_XS32BCD : K_BCD2XS3;
    endfunction

    // BCD input must be 0..9; Excess-3 input must encode 0..9, i.e. 3..12.
    function automatic logic digit_invalid(input mode_e m, input logic [DIGIT_W-1:0] d);
        if (m == MODE_BCD2XS3) begin
            return (d > 4'd9);
        end
        return (d < 4'd3) || (d > 4'd12);
    endfunction

endpackage

// File: rtl/bcd_xs3_serial_conv_add.sv
// serial_add_const: 1-bit Mealy full adder, sum same cycle as a/k, carry registered.
// No backpressure; clr zeroes the carry for the following cycle.
module serial_add_const (
    input  logic clk,
    input  logic reset_b,
    input  logic clr,
    input  logic a,
    input  logic k,
    output logic sum
);

    logic carry;

    assign sum = a ^ k ^ carry;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else begin
            carry <= (a & k) | (a & carry) | (k & carry);
        end
    end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Serial BCD<->Excess-3 converter, 0-cycle Mealy output, 4*N_DIGITS cycles per frame.
// No backpressure; BCD_XS3_ERRCHK_EN adds the invalid-digit error flag.
module bcd_xs3_serial_conv
    import bcd_xs3_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic clk,
    input  logic reset_b,
    input  logic start,
    input  logic mode,
    input  logic B_in,
    output logic B_out,
    output logic out_valid,
    output logic digit_done,
    output logic frame_done,
    output logic error
);

    localparam int DIG_CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;
    localparam logic [DIG_CNT_W-1:0] DIG_LAST = DIG_CNT_W'(N_DIGITS - 1);

    logic [0:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DIG_CNT_W-1:0] dig_cnt;
    mode_e                mode_q;

    logic                 in_idle;
    logic                 last_bit;
    logic                 frame_end;
    logic                 accept;
    logic                 active;
    mode_e                mode_eff;
    logic [DIGIT_W-1:0]   k_vec;
    logic                 sum;

    assign in_idle   = (state == S_IDLE);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign frame_end = (state == S_RUN) && last_bit && (dig_cnt == DIG_LAST);

    // A start during the frame_done cycle opens the next frame on the following
    // cycle, so out_valid stays high with no gap between frames.
    assign accept = reset_b && start && (in_idle || frame_end);
    assign active = reset_b && ((state == S_RUN) || accept);

    // The current frame keeps its latched mode even when a back-to-back start
    // latches a new one in its last cycle.
    assign mode_eff = in_idle ? mode_e'(mode) : mode_q;
    assign k_vec    = k_of(mode_eff);

    serial_add_const u_add (
        .clk     (clk),
        .reset_b (reset_b),
        .clr     (!active || last_bit),
        .a       (B_in),
        .k       (k_vec[bit_cnt]),
        .sum     (sum)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state  <= S_IDLE;
            mode_q <= MODE_BCD2XS3;
        end else begin
            if (accept) begin
                state  <= S_RUN;
                mode_q <= mode_e'(mode);
            end else if (frame_end) begin
                state  <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bit_cnt <= '0;
            dig_cnt <= '0;
        end else if (active) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
                dig_cnt <= (dig_cnt == DIG_LAST) ? '0 : dig_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = active;
    assign B_out      = active && sum;
    assign digit_done = active && last_bit;
    assign frame_done = digit_done && (dig_cnt == DIG_LAST);

`ifdef BCD_XS3_ERRCHK_EN
    logic [DIGIT_W-2:0] low_bits;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            low_bits <= '0;
        end else if (active) begin
            low_bits <= {B_in, low_bits[DIGIT_W-2:1]};
        end
    end

    assign error = digit_done && digit_invalid(mode_eff, {B_in, low_bits});
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Directed bench: one N_DIGITS=1 and one N_DIGITS=3 instance share the inputs.
// Output vector order in every check: {B_out, out_valid, digit_done, frame_done, error}.
module tb_bcd_xs3_serial_conv;

`ifdef BCD_XS3_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic b_in = 1'b0;

    logic b_out1, vld1, dd1, fd1, err1;
    logic b_out3, vld3, dd3, fd3, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_xs3_serial_conv #(.N_DIGITS(1)) dut1 (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (start),
        .mode       (mode),
        .B_in       (b_in),
        .B_out      (b_out1),
        .out_valid  (vld1),
        .digit_done (dd1),
        .frame_done (fd1),
        .error      (err1)
    );

    bcd_xs3_serial_conv #(.N_DIGITS(3)) dut3 (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (start),
        .mode       (mode),
        .B_in       (b_in),
        .B_out      (b_out3),
        .out_valid  (vld3),
        .digit_done (dd3),
        .frame_done (fd3),
        .error      (err3)
    );

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic s, input logic m, input logic b);
        @(negedge clk);
        start = s;
        mode  = m;
        b_in  = b;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        start   = 1'b0;
        b_in    = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    // Single-digit frame on the N_DIGITS=1 instance; mode toggles after start
    // and must have no effect.
    task automatic run1(input logic m, input logic [3:0] din, input logic [3:0] dexp,
                        input logic bad);
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, (i == 0) ? m : ~m, din[i]);
            chk($sformatf("n1_m%0d_d%0d_bit%0d", m, din, i),
                {b_out1, vld1, dd1, fd1, err1},
                {dexp[i], 1'b1, i == 3, i == 3, (i == 3) && bad && ERRCHK});
        end
        drive(1'b0, m, 1'b1);
        chk($sformatf("n1_m%0d_d%0d_idle", m, din), {b_out1, vld1, dd1, fd1, err1}, 5'b0);
    endtask

    // Three-digit frame on the N_DIGITS=3 instance. din/dexp pack {d2,d1,d0},
    // LSB first in time. junk_cyc places a start that must be ignored.
    task automatic frame3(input string name, input logic m, input logic [11:0] din,
                          input logic [11:0] dexp, input logic first_start,
                          input logic end_start, input logic end_mode,
                          input int junk_cyc, input int ncyc);
        logic s, md;
        for (int c = 0; c < ncyc; c++) begin
            s  = (c == 0 && first_start) || (c == junk_cyc) || (c == 11 && end_start);
            md = (c == 0 && first_start) ? m : ((c == 11 && end_start) ? end_mode : ~m);
            drive(s, md, din[c]);
            chk($sformatf("%s_c%0d", name, c),
                {b_out3, vld3, dd3, fd3, err3},
                {dexp[c], 1'b1, (c % 4) == 3, c == 11, 1'b0});
        end
    endtask

    initial begin
        // Reset holds every output low even with start asserted.
        start = 1'b1;
        b_in  = 1'b1;
        #2;
        chk("reset_n1", {b_out1, vld1, dd1, fd1, err1}, 5'b0);
        chk("reset_n3", {b_out3, vld3, dd3, fd3, err3}, 5'b0);
        do_reset();

        run1(1'b0, 4'd5,  4'd8,  1'b0);
        run1(1'b1, 4'd12, 4'd9,  1'b0);
        run1(1'b1, 4'd3,  4'd0,  1'b0);
        run1(1'b0, 4'd0,  4'd3,  1'b0);
        run1(1'b0, 4'd10, 4'd13, 1'b1);
        run1(1'b1, 4'd2,  4'd15, 1'b1);
        run1(1'b1, 4'd13, 4'd10, 1'b1);

        // Three back-to-back frames; frame b ends on 12 (carry out of bit 3),
        // frame b digit 0 = 5 carries into digit 1 unless cleared.
        do_reset();
        frame3("f3a", 1'b0, 12'h709, 12'hA3C, 1'b1, 1'b1, 1'b1, 5, 12);
        frame3("f3b", 1'b1, 12'hC35, 12'h902, 1'b0, 1'b1, 1'b0, -1, 12);
        frame3("f3c", 1'b0, 12'h004, 12'h337, 1'b0, 1'b0, 1'b0, -1, 12);
        drive(1'b0, 1'b0, 1'b1);
        chk("f3_idle", {b_out3, vld3, dd3, fd3, err3}, 5'b0);

        // Reset during cycle 6 of a frame, then a fresh frame.
        frame3("rst_pre", 1'b0, 12'h709, 12'hA3C, 1'b1, 1'b0, 1'b0, -1, 6);
        @(negedge clk);
        b_in    = 1'b1;
        reset_b = 1'b0;
        #1;
        chk("rst_mid", {b_out3, vld3, dd3, fd3, err3}, 5'b0);
        @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk($sformatf("rst_idle%0d", i), {b_out3, vld3, dd3, fd3, err3}, 5'b0);
        end
        frame3("rst_post", 1'b0, 12'h004, 12'h337, 1'b1, 1'b0, 1'b0, -1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
